// File: rtl/gcd_dispatch.sv
// gcd_dispatch: buffers operand pairs in a small FIFO and issues them one
// at a time to a downstream GCD core. Only one pair is outstanding at a time.
// The next pair is issued after the core reports that its result is complete.
module gcd_dispatch #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_x,
   input  logic [WIDTH-1:0]         in_y,
   input  logic                     core_input_ready,
   output logic                     core_input_valid,
   output logic [WIDTH-1:0]         core_x,
   output logic [WIDTH-1:0]         core_y,
   input  logic                     core_output_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy,
   output logic                     err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] ZERO_COUNT = {CW{1'b0}};
   localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
   localparam logic [PW-1:0] ONE_PTR    = PW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10
   } state_t;

   state_t                 state_r;
   state_t                 state_s;

   logic [2*WIDTH-1:0]     mem_r [DEPTH];
   logic [PW-1:0]          wr_ptr_r;
   logic [PW-1:0]          rd_ptr_r;
   logic [CW-1:0]          count_r;
   logic [CW-1:0]          count_s;
   logic [2*WIDTH-1:0]     head_s;

   logic [WIDTH-1:0]       core_x_r;
   logic [WIDTH-1:0]       core_y_r;
   logic                   issue_r;
   logic                   busy_r;
   logic                   err_r;

   logic                   full_s;
   logic                   push_s;
   logic                   pop_s;
   logic                   err_set_s;

   // The full flag comes from the registered count alone, so a pop in the
   // same cycle never opens a slot for a simultaneous push.
   assign full_s   = (count_r == FULL_COUNT);
   assign in_ready = ~full_s;
   assign push_s   = in_valid & ~full_s;
   // Pop only from the registered count: a pair pushed this cycle is not
   // visible to the issue logic until the following edge (no bypass).
   assign pop_s    = (state_r == IDLE) & (count_r != ZERO_COUNT) & core_input_ready;
   assign head_s   = mem_r[rd_ptr_r];

   assign count            = count_r;
   assign core_x           = core_x_r;
   assign core_y           = core_y_r;
   assign core_input_valid = issue_r;
   assign busy             = busy_r;
   assign err              = err_r;

   // Next-state logic for the issue FSM.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (pop_s) begin
               state_s = ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            state_s = WAIT;
         end
         WAIT: begin
            if (core_output_valid) begin
               state_s = IDLE;
            end else begin
               state_s = WAIT;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Next occupancy: a push and a pop in the same cycle cancel out.
   always_comb begin
      count_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + ONE_COUNT;
         2'b01:   count_s = count_r - ONE_COUNT;
         default: count_s = count_r;
      endcase
   end

   // Protocol errors: a result arriving while no pair is being waited on,
   // or a producer offering a pair into a full FIFO (that pair is dropped).
   always_comb begin
      err_set_s = 1'b0;
      if (core_output_valid && ((state_r == IDLE) || (state_r == ISSUE))) begin
         err_set_s = 1'b1;
      end else if (in_valid && full_s) begin
         err_set_s = 1'b1;
      end else begin
         err_set_s = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {in_x, in_y};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= ZERO_COUNT;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + ONE_PTR;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + ONE_PTR;
         end
         count_r <= count_s;
      end
   end

   // Operand registers: loaded only at the issuing edge and held until the next one.
   always_ff @(posedge clk) begin
      if (reset) begin
         core_x_r <= {WIDTH{1'b0}};
         core_y_r <= {WIDTH{1'b0}};
      end else if (pop_s) begin
         core_x_r <= head_s[2*WIDTH-1:WIDTH];
         core_y_r <= head_s[WIDTH-1:0];
      end
   end

   // Registered status outputs, decoded from the next state so they line up with state_r.
   always_ff @(posedge clk) begin
      if (reset) begin
         issue_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         issue_r <= (state_s == ISSUE);
         busy_r  <= (state_s != IDLE);
      end
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_r <= 1'b0;
      end else if (err_set_s) begin
         err_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_gcd_dispatch.sv
// Self-checking bench for gcd_dispatch: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_gcd_dispatch;

   localparam int W = 32;
   localparam int D = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [W-1:0]      in_x = '0;
   logic [W-1:0]      in_y = '0;
   logic              core_input_ready = 1'b0;
   logic              core_input_valid;
   logic [W-1:0]      core_x;
   logic [W-1:0]      core_y;
   logic              core_output_valid = 1'b0;
   logic [$clog2(D):0] count;
   logic              busy;
   logic              err;

   always #5 clk = ~clk;

   gcd_dispatch #(.WIDTH(W), .DEPTH(D)) dut (
      .clk               (clk),
      .reset             (reset),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_x              (in_x),
      .in_y              (in_y),
      .core_input_ready  (core_input_ready),
      .core_input_valid  (core_input_valid),
      .core_x            (core_x),
      .core_y            (core_y),
      .core_output_valid (core_output_valid),
      .count             (count),
      .busy              (busy),
      .err               (err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: queued pairs, whether a pair is outstanding, issue pulse
   bit [2*W-1:0] mq[$];
   bit           m_busy  = 1'b0;
   bit           m_issue = 1'b0;
   bit           m_err   = 1'b0;
   bit [W-1:0]   m_x     = '0;
   bit [W-1:0]   m_y     = '0;

   // behavioural core: countdown after each issue, then a one-cycle result pulse
   int core_cnt   = -1;
   int core_lat   = 10;
   bit hold_cir   = 1'b0;
   bit spur       = 1'b0;
   bit rand_lat   = 1'b0;
   bit chk_gap    = 1'b0;
   int tcount     = 0;
   int last_cov_t = -100;
   int gap_from   = 0;
   int n_issue    = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, tcount);
      end
   endtask

   function automatic longint unsigned gcd_of(input longint unsigned a, input longint unsigned b);
      longint unsigned t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // one clock cycle: drive core, advance model, step clock, compare
   task automatic tick();
      bit [2*W-1:0] pr;
      int sz;
      core_input_ready  = (core_cnt < 0) && !hold_cir;
      core_output_valid = (core_cnt == 0) || spur;
      sz = mq.size();
      if (reset) begin
         mq.delete();
         m_busy = 1'b0; m_issue = 1'b0; m_err = 1'b0; m_x = '0; m_y = '0;
      end else begin
         if ((core_output_valid && !(m_busy && !m_issue)) || (in_valid && sz == D))
            m_err = 1'b1;
         if (!m_busy && sz > 0 && core_input_ready) begin
            pr = mq.pop_front();
            m_x = pr[2*W-1:W];
            m_y = pr[W-1:0];
            m_busy = 1'b1;
            m_issue = 1'b1;
         end else if (m_issue) begin
            m_issue = 1'b0;
         end else if (m_busy && core_output_valid) begin
            m_busy = 1'b0;
         end
         if (in_valid && sz != D)
            mq.push_back({in_x, in_y});
      end
      @(posedge clk);
      #1;
      tcount++;
      if (core_cnt == 0) core_cnt = -1;
      else if (core_cnt > 0) core_cnt--;
      if (core_input_valid) begin
         n_issue++;
         if (rand_lat) core_lat = $urandom_range(1, 6);
         core_cnt = core_lat;
         if (chk_gap && last_cov_t >= gap_from)
            check_val("issue_gap", 64'(tcount - last_cov_t), 64'd1);
      end
      if (core_output_valid) last_cov_t = tcount;
      check_val("core_input_valid", 64'(core_input_valid), 64'(m_issue));
      check_val("busy",     64'(busy),     64'(m_busy));
      check_val("count",    64'(count),    64'(mq.size()));
      check_val("in_ready", 64'(in_ready), 64'(mq.size() != D));
      check_val("err",      64'(err),      64'(m_err));
      check_val("core_x",   64'(core_x),   64'(m_x));
      check_val("core_y",   64'(core_y),   64'(m_y));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
      in_valid = 1'b1; in_x = x; in_y = y;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0;
      tick(); tick();
      reset = 1'b0;
      core_cnt = -1; hold_cir = 1'b0; spur = 1'b0;
   endtask

   int base;

   initial begin
      // reset state
      do_reset();
      check_val("rst_in_ready", 64'(in_ready), 64'd1);

      // single pair with a known result
      core_lat = 10;
      base = n_issue;
      push(32'd3322124436, 32'd2637132290);
      run(30);
      check_val("single_issues", 64'(n_issue - base), 64'd1);
      check_val("single_gcd", gcd_of(64'(core_x), 64'(core_y)), 64'd2);
      check_val("single_busy", 64'(busy), 64'd0);

      // four pairs queued, then issued back to back in order
      do_reset();
      core_lat = 10; hold_cir = 1'b1;
      base = n_issue;
      for (int i = 0; i < 4; i++) push($urandom, $urandom);
      check_val("four_count", 64'(count), 64'd4);
      hold_cir = 1'b0; chk_gap = 1'b1; gap_from = tcount;
      run(60);
      chk_gap = 1'b0;
      check_val("four_issues", 64'(n_issue - base), 64'd4);

      // overflow: fifth pair offered into a full FIFO
      do_reset();
      hold_cir = 1'b1;
      base = n_issue;
      for (int i = 0; i < 4; i++) push(W'(100 + i), W'(200 + i));
      in_valid = 1'b1; in_x = 32'hDEAD_BEEF; in_y = 32'h1234_5678;
      tick(); tick();
      in_valid = 1'b0;
      check_val("ovf_err", 64'(err), 64'd1);
      check_val("ovf_count", 64'(count), 64'd4);
      hold_cir = 1'b0;
      run(60);
      check_val("ovf_issues", 64'(n_issue - base), 64'd4);

      // core not ready for 20 cycles
      do_reset();
      hold_cir = 1'b1;
      base = n_issue;
      push($urandom, $urandom);
      push($urandom, $urandom);
      run(20);
      check_val("hold_no_issue", 64'(n_issue - base), 64'd0);
      hold_cir = 1'b0;
      tick();
      check_val("hold_issue_edge", 64'(core_input_valid), 64'd1);
      run(40);

      // reset while waiting with two pairs queued
      do_reset();
      core_lat = 10;
      push($urandom, $urandom);
      push($urandom, $urandom);
      push($urandom, $urandom);
      tick();
      check_val("wait_busy", 64'(busy), 64'd1);
      check_val("wait_count", 64'(count), 64'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_val("rst_wait_count", 64'(count), 64'd0);
      check_val("rst_wait_busy", 64'(busy), 64'd0);
      check_val("rst_wait_civ", 64'(core_input_valid), 64'd0);
      base = n_issue;
      run(15);
      check_val("late_result_err", 64'(err), 64'd1);
      check_val("late_result_busy", 64'(busy), 64'd0);
      check_val("late_result_no_issue", 64'(n_issue - base), 64'd0);

      // spurious result while idle
      do_reset();
      spur = 1'b1;
      tick();
      spur = 1'b0;
      check_val("spur_err", 64'(err), 64'd1);
      base = n_issue;
      push($urandom, $urandom);
      push($urandom, $urandom);
      run(40);
      check_val("spur_issues", 64'(n_issue - base), 64'd2);
      check_val("spur_err_sticky", 64'(err), 64'd1);

      // random traffic against the model
      do_reset();
      rand_lat = 1'b1;
      base = n_issue;
      for (int i = 0; i < 600; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_x = $urandom;
         in_y = $urandom;
         hold_cir = ($urandom_range(0, 3) == 0);
         tick();
      end
      in_valid = 1'b0; hold_cir = 1'b0;
      run(60);
      check_val("rand_issued", 64'(n_issue - base > 0), 64'd1);
      check_val("rand_drained", 64'(count), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gcd_dispatch.md
GCD_DISPATCH -- requirements
Module: gcd_dispatch

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits.
REQ-002 Parameter DEPTH, default 4: operand-pair FIFO depth, a power of two and at least 2.
REQ-003 clk  in  1: single clock; all state updates on the rising edge.
REQ-004 reset  in  1: synchronous, active-high reset, shared with the downstream GCD core.
REQ-005 in_valid  in  1: producer offers an operand pair.
REQ-006 in_ready  out  1: FIFO can accept a pair.
REQ-007 in_x  in  WIDTH: producer operand x.
REQ-008 in_y  in  WIDTH: producer operand y.
REQ-009 core_input_ready  in  1: core idle and able to accept operands.
REQ-010 core_input_valid  out  1: one-cycle issue pulse to the core.
REQ-011 core_x  out  WIDTH: operand x presented to the core.
REQ-012 core_y  out  WIDTH: operand y presented to the core.
REQ-013 core_output_valid  in  1: core signals that its result is complete.
REQ-014 count  out  $clog2(DEPTH)+1: number of pairs queued in the FIFO.
REQ-015 busy  out  1: an issued pair has no result yet, i.e. state is ISSUE or WAIT.
REQ-016 err  out  1: sticky protocol-error flag.

Function
REQ-017 The FIFO pushes {in_x, in_y} on every edge where in_valid && in_ready.
REQ-018 in_ready = (count != DEPTH), derived from registered count only; a pop in the same cycle does not raise in_ready when the FIFO is full.
REQ-019 The FSM has states IDLE, ISSUE and WAIT, with encoded state internal to the module.
REQ-020 IDLE -> ISSUE transition:
- taken at an edge where count > 0 && core_input_ready;
- at that edge the head pair loads into core_x and core_y;
- the head pair is popped at the same edge.
REQ-021 core_input_valid = 1 exactly while the state is ISSUE (one cycle); ISSUE -> WAIT is unconditional.
REQ-022 WAIT -> IDLE at an edge where core_output_valid = 1; otherwise the FSM stays in WAIT with no timeout.
REQ-023 core_x and core_y hold their values from the load until the next issue and are never altered during ISSUE or WAIT.
REQ-024 At most one pair is in flight; no new issue occurs before the result for the current pair returns.
REQ-025 Back-to-back issue:
- WAIT -> IDLE on edge E;
- IDLE -> ISSUE at the next edge E+1 if the IDLE conditions hold.
REQ-026 Latency: a pair pushed at edge E0 into an empty FIFO with the FSM IDLE and core_input_ready = 1 gives core_input_valid high in the cycle following edge E0+1.
REQ-027 A simultaneous push and pop is permitted and leaves count unchanged.
REQ-028 A push into an empty FIFO is not issuable in the same cycle; there is no bypass path.
REQ-029 FIFO pointers wrap modulo DEPTH; FIFO order is strictly first in, first out.
REQ-030 err sets and remains 1 until reset when either of these occurs:
- core_output_valid = 1 while the state is IDLE or ISSUE;
- in_valid = 1 while in_ready = 0 and the FIFO is full; in this case the pair is dropped and not pushed.
REQ-031 Operands pass through unmodified, with no width conversion and no zero-operand filtering.

Reset
REQ-032 While reset = 1 at an edge:
- state <= IDLE; FIFO empty; count = 0;
- core_input_valid = 0; busy = 0; err = 0;
- core_x = 0; core_y = 0.
REQ-033 Reset asserted during ISSUE or WAIT abandons the in-flight pair and all queued pairs.
REQ-034 After reset deasserts, no issue occurs until a new push arrives and core_input_ready = 1.
REQ-035 in_ready = 1 on the first cycle after reset deasserts.

Verification
REQ-036 The bench covers the following directed scenarios:
- Single pair (x = 3322124436, y = 2637132290), core idle -> exactly one cycle of core_input_valid, core_x/core_y equal to the pair; core result = 2; busy drops after core_output_valid.
- Four pairs pushed on consecutive cycles, each core taking 10 cycles -> four issues in push order; count goes 4,3,2,1,0; each issue follows the previous core_output_valid by exactly 1 cycle.
- Fifth push while count = 4 and in_valid held high -> in_ready = 0; pair not stored; err = 1; the earlier four pairs are unaffected.
- Pairs queued with core_input_ready held 0 for 20 cycles -> no core_input_valid; the issue occurs one edge after core_input_ready rises.
- Reset asserted in WAIT with 2 pairs queued -> next cycle count = 0, busy = 0, core_input_valid = 0; a later core_output_valid pulse does not move the FSM but sets err.
- Spurious core_output_valid while IDLE -> err = 1 and stays 1; FIFO and issue behaviour unchanged.
